// File: rtl/serial_shift_ctrl.sv
// serial_shift_ctrl
//
// Parallel-to-serial frame controller. A word offered on the s_valid/s_ready
// handshake is loaded into a shift register and sent out MSB first, one bit
// per clock, for an effective length of 1..N bits. After a completed frame
// the controller stays busy for GAP idle cycles before it accepts the next
// word. An abort ends a frame early and suppresses the done pulse.
//
// Handshake: a word is transferred in any cycle where s_valid and s_ready
// are both high at the rising edge of clk. s_ready is high only in IDLE with
// abort low, and it does not depend on s_valid. A word offered while the
// controller is busy stays pending until it is accepted.
//
// Parameters
//   N    word / shift register width (>= 2)
//   GAP  idle cycles after each completed frame (0..15)
//
// Ports
//   clk        clock; all state updates on its rising edge
//   resetn     synchronous active-low reset
//   s_valid    upstream word valid
//   s_ready    controller accepts a word this cycle
//   s_data     parallel word, sent MSB first
//   s_len      bits to send; 0 means N, values above N are clamped to N
//   abort      terminates the current frame (SHIFT or GAP)
//   ser_out    serial data bit (0 when ser_en is low)
//   ser_en     ser_out carries a valid bit
//   busy       high in SHIFT or GAP
//   done       one-cycle pulse after the last bit of a completed frame
//   dbg_state  current FSM state (0 IDLE, 1 SHIFT, 2 GAP)

module serial_shift_ctrl #(
  parameter int N   = 8,
  parameter int GAP = 1,
  localparam int CW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [N-1:0]  s_data,
  input  logic [CW-1:0] s_len,
  input  logic          abort,
  output logic          ser_out,
  output logic          ser_en,
  output logic          busy,
  output logic          done,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [N-1:0]  r_sreg;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_gap;
  logic          r_done;

  logic          w_idle;
  logic          w_hs;
  logic          w_last;
  logic [CW-1:0] w_len_eff;

  assign w_idle = (r_state == ST_IDLE);
  assign w_hs   = s_valid && w_idle && !abort;

  // The cycle that drives the final bit of the frame.
  assign w_last = (r_state == ST_SHIFT) && (r_cnt == CW'(1));

  // Length 0 and anything larger than the register both mean a full word.
  always_comb begin
    w_len_eff = s_len;
    if ((s_len == '0) || (s_len > CW'(N))) begin
      w_len_eff = CW'(N);
    end
  end

  // State register plus datapath.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
      r_sreg  <= '0;
      r_cnt   <= '0;
      r_gap   <= 4'd0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      // Only a frame that reaches its last bit without abort reports done.
      r_done  <= w_last && !abort;
      case (r_state)
        ST_IDLE: begin
          if (w_hs) begin
            r_sreg <= s_data;
            r_cnt  <= w_len_eff;
            r_gap  <= 4'd0;
          end
        end
        ST_SHIFT: begin
          if (abort) begin
            r_sreg <= '0;
            r_cnt  <= '0;
            r_gap  <= 4'd0;
          end else begin
            r_sreg <= {r_sreg[N-2:0], 1'b0};
            r_cnt  <= r_cnt - CW'(1);
            // The gap counter holds the number of GAP cycles left after
            // the current one, so it starts at GAP-1.
            if (w_last && (GAP > 0)) begin
              r_gap <= 4'(GAP - 1);
            end
          end
        end
        ST_GAP: begin
          if (abort) begin
            r_sreg <= '0;
            r_cnt  <= '0;
            r_gap  <= 4'd0;
          end else if (r_gap != 4'd0) begin
            r_gap <= r_gap - 4'd1;
          end
        end
        default: begin
          r_sreg <= '0;
          r_cnt  <= '0;
          r_gap  <= 4'd0;
        end
      endcase
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_hs) begin
          w_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (abort) begin
          w_next = ST_IDLE;
        end else if (w_last) begin
          w_next = (GAP > 0) ? ST_GAP : ST_IDLE;
        end
      end
      ST_GAP: begin
        if (abort || (r_gap == 4'd0)) begin
          w_next = ST_IDLE;
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Outputs decoded from registered state (s_ready also honours abort).
  always_comb begin
    s_ready   = w_idle && !abort;
    ser_en    = (r_state == ST_SHIFT);
    ser_out   = (r_state == ST_SHIFT) && r_sreg[N-1];
    busy      = !w_idle;
    done      = r_done;
    dbg_state = r_state;
  end

endmodule

// File: tb/tb_serial_shift_ctrl.sv
// Bench for serial_shift_ctrl. Two instances share all inputs: dut_a uses
// GAP=2 and dut_b uses GAP=0. Each cycle inputs change on the falling edge and
// outputs are compared 1 ns later as {s_ready, ser_en, ser_out, done, busy}.

module tb_serial_shift_ctrl;

  localparam int N  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          resetn;
  logic          s_valid;
  logic [N-1:0]  s_data;
  logic [CW-1:0] s_len;
  logic          abort;

  logic          a_ready, a_ser_out, a_ser_en, a_busy, a_done;
  logic [1:0]    a_state;
  logic          b_ready, b_ser_out, b_ser_en, b_busy, b_done;
  logic [1:0]    b_state;

  int errors = 0;
  int checks = 0;
  logic rn_drv = 1'b0;

  typedef struct {
    logic          v;
    logic [N-1:0]  d;
    logic [CW-1:0] l;
    logic          a;
    logic [4:0]    exp;
  } vec_t;

  typedef struct {
    logic          v;
    logic [N-1:0]  d;
    logic [CW-1:0] l;
    logic          a;
  } stim_t;

  vec_t        tbl[19];
  stim_t       stim_q[$];
  logic [4:0]  exp_q[$];

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    resetn  = 1'b0;
    s_valid = 1'b1;
    s_data  = 8'h00;
    s_len   = 4'd0;
    abort   = 1'b0;
  end

  serial_shift_ctrl #(.N(N), .GAP(2)) dut_a (
    .clk(clk), .resetn(resetn), .s_valid(s_valid), .s_ready(a_ready),
    .s_data(s_data), .s_len(s_len), .abort(abort), .ser_out(a_ser_out),
    .ser_en(a_ser_en), .busy(a_busy), .done(a_done), .dbg_state(a_state)
  );

  serial_shift_ctrl #(.N(N), .GAP(0)) dut_b (
    .clk(clk), .resetn(resetn), .s_valid(s_valid), .s_ready(b_ready),
    .s_data(s_data), .s_len(s_len), .abort(abort), .ser_out(b_ser_out),
    .ser_en(b_ser_en), .busy(b_busy), .done(b_done), .dbg_state(b_state)
  );

  // Helpers
  function automatic logic [4:0] vv(input logic rdy, input logic en,
                                    input logic out, input logic dn,
                                    input logic bsy);
    return {rdy, en, out, dn, bsy};
  endfunction

  function automatic vec_t mk(input logic v, input logic [N-1:0] d,
                              input logic [CW-1:0] l, input logic a,
                              input logic [4:0] exp);
    vec_t r;
    r.v = v; r.d = d; r.l = l; r.a = a; r.exp = exp;
    return r;
  endfunction

  function automatic logic [4:0] got(input bit sel);
    if (sel) return {b_ready, b_ser_en, b_ser_out, b_done, b_busy};
    return {a_ready, a_ser_en, a_ser_out, a_done, a_busy};
  endfunction

  // Driver tasks
  task automatic drive(input logic v, input logic [N-1:0] d,
                       input logic [CW-1:0] l, input logic a);
    @(negedge clk);
    resetn  = rn_drv;
    s_valid = v;
    s_data  = d;
    s_len   = l;
    abort   = a;
    #1;
  endtask

  task automatic check(input string name, input bit sel, input logic [4:0] exp);
    logic [4:0] g;
    g = got(sel);
    checks++;
    if (g !== exp) begin
      errors++;
      $display("FAIL %s: rdy/en/out/done/busy got=%b expected=%b (t=%0t)",
               name, g, exp, $time);
    end
  endtask

  task automatic step(input string name, input bit sel, input logic v,
                      input logic [N-1:0] d, input logic [CW-1:0] l,
                      input logic a, input logic [4:0] exp);
    drive(v, d, l, a);
    check(name, sel, exp);
  endtask

  // Reference model for dut_a (GAP=2): builds the per-cycle stimulus and the
  // expected output for one frame straight from the frame rules.
  task automatic model_frame(input logic [N-1:0] d, input logic [CW-1:0] lraw,
                             input int abort_at, input int gap_abort,
                             input int idle_n);
    int    len;
    bit    aborted;
    stim_t s;
    len = (lraw == 0 || lraw > N) ? N : int'(lraw);
    aborted = 0;
    for (int i = 0; i < idle_n; i++) begin
      s.a = ($urandom_range(0, 2) == 0);
      s.v = s.a;                    // a pending word blocked by abort
      s.d = N'($urandom);
      s.l = CW'($urandom);
      stim_q.push_back(s);
      exp_q.push_back(vv(!s.a, 0, 0, 0, 0));
    end
    s.v = 1; s.d = d; s.l = lraw; s.a = 0;
    stim_q.push_back(s);
    exp_q.push_back(vv(1, 0, 0, 0, 0));
    for (int k = 0; k < len; k++) begin
      s.v = 1'($urandom); s.d = N'($urandom); s.l = CW'($urandom);
      s.a = (k == abort_at);
      stim_q.push_back(s);
      exp_q.push_back(vv(0, 1, d[N-1-k], 0, 1));
      if (s.a) begin
        aborted = 1;
        break;
      end
    end
    if (!aborted) begin
      for (int g = 0; g < 2; g++) begin
        s.v = 1'($urandom); s.d = N'($urandom); s.l = CW'($urandom);
        s.a = (g == gap_abort);
        stim_q.push_back(s);
        exp_q.push_back(vv(0, 0, 0, (g == 0), 1));
        if (s.a) break;
      end
    end
  endtask

  task automatic apply_model(input string name);
    stim_t      s;
    logic [4:0] e;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      step(name, 0, s.v, s.d, s.l, s.a, e);
    end
  endtask

  // Test sequence
  initial begin
    logic [N-1:0] a5_bits;
    logic [2:0]   c0_bits;
    logic [N-1:0] w1, w2, rd;
    logic [CW-1:0] rl;
    int           r, ab_at, gab, len;

    a5_bits = 8'b1010_0101;
    c0_bits = 3'b110;

    // A5 frame with s_valid held (different data) during busy, then a C0
    // frame of length 3 accepted on the first idle cycle.
    tbl[0] = mk(1, 8'hA5, 4'd8, 0, vv(1, 0, 0, 0, 0));
    for (int k = 0; k < 8; k++)
      tbl[1+k] = mk(1, 8'h3C, 4'd2, 0, vv(0, 1, a5_bits[7-k], 0, 1));
    tbl[9]  = mk(1, 8'h3C, 4'd2, 0, vv(0, 0, 0, 1, 1));
    tbl[10] = mk(1, 8'h3C, 4'd2, 0, vv(0, 0, 0, 0, 1));
    tbl[11] = mk(1, 8'hC0, 4'd3, 0, vv(1, 0, 0, 0, 0));
    for (int k = 0; k < 3; k++)
      tbl[12+k] = mk(0, 8'hFF, 4'd8, 0, vv(0, 1, c0_bits[2-k], 0, 1));
    tbl[15] = mk(0, 8'h00, 4'd0, 0, vv(0, 0, 0, 1, 1));
    tbl[16] = mk(0, 8'h00, 4'd0, 0, vv(0, 0, 0, 0, 1));
    tbl[17] = mk(0, 8'h00, 4'd0, 0, vv(1, 0, 0, 0, 0));
    tbl[18] = mk(0, 8'h00, 4'd0, 0, vv(1, 0, 0, 0, 0));

    // Reset held two cycles with s_valid high.
    rn_drv = 0;
    step("reset_c1", 0, 1, 8'hFF, 4'd8, 0, vv(1, 0, 0, 0, 0));
    step("reset_c2", 0, 1, 8'hFF, 4'd8, 0, vv(1, 0, 0, 0, 0));
    check("reset_c2_b", 1, vv(1, 0, 0, 0, 0));
    rn_drv = 1;
    step("reset_release", 0, 0, 8'h00, 4'd0, 0, vv(1, 0, 0, 0, 0));
    step("reset_no_hs", 0, 0, 8'h00, 4'd0, 0, vv(1, 0, 0, 0, 0));

    // Table vectors.
    for (int i = 0; i < 19; i++)
      step($sformatf("tbl_%0d", i), 0, tbl[i].v, tbl[i].d, tbl[i].l,
           tbl[i].a, tbl[i].exp);

    // Length 0 and 12 both give a full 8-bit frame.
    model_frame(8'h81, 4'd0, -1, -1, 0);
    apply_model("len0");
    model_frame(8'h5A, 4'd12, -1, -1, 1);
    apply_model("len12");

    // Abort on the 4th bit of an FF frame.
    step("abort_hs", 0, 1, 8'hFF, 4'd8, 0, vv(1, 0, 0, 0, 0));
    for (int k = 0; k < 3; k++)
      step("abort_bit", 0, 0, 8'h00, 4'd0, 0, vv(0, 1, 1, 0, 1));
    step("abort_at4", 0, 0, 8'h00, 4'd0, 1, vv(0, 1, 1, 0, 1));
    step("abort_after", 0, 0, 8'h00, 4'd0, 0, vv(1, 0, 0, 0, 0));
    step("abort_nodone", 0, 0, 8'h00, 4'd0, 0, vv(1, 0, 0, 0, 0));

    // Abort in IDLE blocks a pending word for that cycle only.
    step("idle_abort", 0, 1, 8'h11, 4'd1, 1, vv(0, 0, 0, 0, 0));
    step("idle_abort_nohs", 0, 0, 8'h00, 4'd0, 0, vv(1, 0, 0, 0, 0));

    // Reset at bit 5 of a frame.
    step("rst_hs", 0, 1, 8'hB6, 4'd8, 0, vv(1, 0, 0, 0, 0));
    for (int k = 0; k < 4; k++)
      step("rst_bit", 0, 0, 8'h00, 4'd0, 0, vv(0, 1, rd_bit(8'hB6, k), 0, 1));
    rn_drv = 0;
    step("rst_at5", 0, 0, 8'h00, 4'd0, 0, vv(0, 1, 0, 0, 1));
    rn_drv = 1;
    step("rst_after", 0, 0, 8'h00, 4'd0, 0, vv(1, 0, 0, 0, 0));
    step("rst_nodone", 0, 0, 8'h00, 4'd0, 0, vv(1, 0, 0, 0, 0));

    // Randomized frames against the model.
    for (int f = 0; f < 40; f++) begin
      rd = N'($urandom);
      rl = CW'($urandom_range(0, 15));
      len = (rl == 0 || rl > N) ? N : int'(rl);
      r = $urandom_range(0, 9);
      ab_at = (r < 3) ? $urandom_range(0, len - 1) : -1;
      gab   = (r == 3) ? $urandom_range(0, 1) : -1;
      model_frame(rd, rl, ab_at, gab, $urandom_range(0, 2));
      apply_model($sformatf("rand_f%0d", f));
    end
    step("rand_tail", 0, 0, 8'h00, 4'd0, 0, vv(1, 0, 0, 0, 0));

    // GAP=0 instance: s_valid held across two words.
    rn_drv = 0;
    step("g0_reset", 1, 0, 8'h00, 4'd0, 0, vv(1, 0, 0, 0, 0));
    step("g0_reset", 1, 0, 8'h00, 4'd0, 0, vv(1, 0, 0, 0, 0));
    rn_drv = 1;
    w1 = 8'h96;
    w2 = 8'h3D;
    step("g0_hs1", 1, 1, w1, 4'd8, 0, vv(1, 0, 0, 0, 0));
    for (int k = 0; k < 8; k++)
      step("g0_f1", 1, 1, w2, 4'd8, 0, vv(0, 1, w1[7-k], 0, 1));
    step("g0_done1_hs2", 1, 1, w2, 4'd8, 0, vv(1, 0, 0, 1, 0));
    for (int k = 0; k < 8; k++)
      step("g0_f2", 1, 0, 8'h00, 4'd0, 0, vv(0, 1, w2[7-k], 0, 1));
    step("g0_done2", 1, 0, 8'h00, 4'd0, 0, vv(1, 0, 0, 1, 0));
    step("g0_idle", 1, 0, 8'h00, 4'd0, 0, vv(1, 0, 0, 0, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  function automatic logic rd_bit(input logic [N-1:0] d, input int k);
    return d[N-1-k];
  endfunction

endmodule

// File: doc/serial_shift_ctrl.md
SERIAL_SHIFT_CTRL -- requirements
Module: serial_shift_ctrl

Interface
REQ-001 Parameter N, default 8: word and shift-register width; SHALL be >= 2.
REQ-002 Parameter GAP, default 1: idle cycles inserted after each frame; SHALL be 0..15.
REQ-003 Local width CW = $clog2(N+1).
REQ-004 clk  in  1  single clock; all state SHALL update on posedge clk only.
REQ-005 resetn  in  1  reset, synchronous, active-low.
REQ-006 s_valid  in  1  upstream word valid.
REQ-007 s_ready  out  1  controller can accept a word this cycle.
REQ-008 s_data  in  N  parallel word, shifted out MSB first.
REQ-009 s_len  in  CW  bits to send; 0 means N; values > N clamp to N.
REQ-010 abort  in  1  terminate the current frame.
REQ-011 ser_out  out  1  serial data bit.
REQ-012 ser_en  out  1  ser_out carries a valid bit this cycle.
REQ-013 busy  out  1  high in SHIFT or GAP.
REQ-014 done  out  1  one-cycle pulse on normal frame completion.

Function
REQ-015 The FSM SHALL have three states: IDLE, SHIFT, GAP; all outputs SHALL be registered or decoded from registered state only.
REQ-016 Accept: s_ready = (state==IDLE) && !abort; handshake = s_valid && s_ready.
REQ-017 On handshake in cycle t: load sreg <= s_data, cnt <= effective length (REQ-009), state <= SHIFT.
REQ-018 In SHIFT: ser_en=1, ser_out=sreg[N-1]; each cycle sreg shifts left with 0 fill and cnt decrements.
REQ-019 Bit k (k=0..L-1, L=effective length) SHALL appear at cycle t+1+k; L bits only; the first bit is s_data[N-1].
REQ-020 When the last bit is driven (cnt==1): next state = GAP if GAP>0, else IDLE.
REQ-021 done SHALL pulse high exactly at cycle t+L+1, once per normally completed frame.
REQ-022 GAP: ser_en=0, s_ready=0, busy=1 for exactly GAP cycles, then IDLE; next handshake no earlier than t+L+1+GAP.
REQ-023 With GAP=0, the controller SHALL return to IDLE at t+L+1: one bubble cycle between frames.
REQ-024 Outside SHIFT: ser_out=0, ser_en=0.
REQ-025 abort sampled high in SHIFT or GAP: the next state SHALL be IDLE, sreg and cnt cleared, done not pulsed; ser_en=0 from the next cycle.
REQ-026 abort high in IDLE: blocks acceptance that cycle (REQ-016); no other effect.
REQ-027 abort and the last SHIFT bit in the same cycle: abort wins; no done.
REQ-028 s_valid held while busy: the word SHALL NOT be consumed; it is accepted on the first IDLE cycle with abort low.
REQ-029 s_data and s_len SHALL be sampled only on handshake; later changes have no effect on the frame in flight.

Reset
REQ-030 resetn low at a clock edge: state=IDLE, sreg=0, cnt=0, gap counter=0.
REQ-031 Outputs during and after reset: ser_out=0, ser_en=0, busy=0, done=0; s_ready=1 from the first cycle after resetn is high.
REQ-032 Reset mid-frame SHALL discard the frame with no done pulse; reset has priority over abort and handshake.

Verification (N=8, GAP=2 unless stated)
REQ-033 Hold resetn low 2 cycles with s_valid=1 -> no handshake, ser_en=0, busy=0, done=0; s_ready=1 on the first cycle after release.
REQ-034 Handshake s_data=8'hA5, s_len=8 at t -> ser_out 1,0,1,0,0,1,0,1 at t+1..t+8; done at t+9; s_ready=0 at t+9..t+10 and 1 at t+11.
REQ-035 s_data=8'hC0, s_len=3 -> bits 1,1,0 at t+1..t+3; done at t+4; s_len=0 and s_len=12 each give 8 bits.
REQ-036 abort at the 4th bit of an 8'hFF frame -> ser_en=0 next cycle, no done, s_ready=1 the cycle after abort.
REQ-037 GAP=0, s_valid held high with two words -> frame 1 at t+1..t+8, done at t+9, second handshake at t+9, frame 2 bits from t+10.
REQ-038 resetn low at bit 5 of a frame -> ser_en=0, busy=0 next cycle; no done pulse.
